// File: rtl/mra_pkg.sv
// Shared types and constants for the MRA frame fetch path (AXI4 read DMA into frame SRAM).
package mra_pkg;

   typedef logic [1:0] axi_burst_t;

   localparam logic [31:0] LOC_BASE     = 32'h0001_0000;
   localparam logic [31:0] WGT_BASE     = 32'h0002_0000;
   localparam int unsigned FRAME_BYTES  = 2048;
   localparam int unsigned BEATS        = 128;
   localparam logic [2:0]  AXI_SIZE_16B = 3'b100;
   localparam axi_burst_t  AXI_INCR     = 2'b01;

   typedef enum logic [1:0] {IDLE, AR, RD, DONE} fetch_state_t;

   // Byte offset of a 2 KB frame inside its map region.
   function automatic logic [31:0] frame_offset(input logic [4:0] fid);
      return {16'h0000, fid, 11'h000};
   endfunction

endpackage

// File: rtl/mra_frame_fetch.sv
// Fetches one 2 KB map frame as a single 128-beat INCR burst and streams it into the frame SRAM.
// Optional build macro RESP_CHECK_EN adds a sticky R-channel protocol error flag.
module mra_frame_fetch
   import mra_pkg::*;
#(
   parameter int unsigned            ID_WIDTH   = 4,
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 128,
   parameter logic [ADDR_WIDTH-1:0]  LOC_BASE   = ADDR_WIDTH'(mra_pkg::LOC_BASE),
   parameter logic [ADDR_WIDTH-1:0]  WGT_BASE   = ADDR_WIDTH'(mra_pkg::WGT_BASE),
   parameter int unsigned            BEATS      = mra_pkg::BEATS,
   localparam int unsigned           CNT_W      = $clog2(BEATS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4:0]            frame_id,
   input  logic                  map_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic                  sram_ready,
   output logic                  sram_we,
   output logic [CNT_W-1:0]      sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   output logic [ID_WIDTH-1:0]   arid_m_inf,
   output logic [ADDR_WIDTH-1:0] araddr_m_inf,
   output logic [7:0]            arlen_m_inf,
   output logic [2:0]            arsize_m_inf,
   output axi_burst_t            arburst_m_inf,
   output logic                  arvalid_m_inf,
   input  logic                  arready_m_inf,
   input  logic [ID_WIDTH-1:0]   rid_m_inf,
   input  logic [DATA_WIDTH-1:0] rdata_m_inf,
   input  logic [1:0]            rresp_m_inf,
   input  logic                  rlast_m_inf,
   input  logic                  rvalid_m_inf,
   output logic                  rready_m_inf
);

   fetch_state_t          r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic                  w_beat;
   logic                  w_last;

   assign w_beat = (r_state == RD) && rvalid_m_inf && sram_ready;
   assign w_last = (r_cnt == CNT_W'(BEATS - 1));

`ifdef RESP_CHECK_EN
   logic r_err;
   logic w_bad;
   assign w_bad = (rresp_m_inf != 2'b00) || (rid_m_inf != '0) || (rlast_m_inf != w_last);
   assign err   = r_err;
`else
   logic w_unused_resp;
   assign w_unused_resp = ^{rid_m_inf, rresp_m_inf, rlast_m_inf};
   assign err           = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_araddr <= '0;
`ifdef RESP_CHECK_EN
         r_err    <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_araddr <= (map_sel ? WGT_BASE : LOC_BASE) + ADDR_WIDTH'(frame_offset(frame_id));
                  r_state  <= AR;
`ifdef RESP_CHECK_EN
                  r_err    <= 1'b0;
`endif
               end
            end
            AR: begin
               if (arready_m_inf) r_state <= RD;
            end
            RD: begin
               // Burst end is counted locally; the counter wraps back to 0 on the final beat.
               if (w_beat) begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) r_state <= DONE;
`ifdef RESP_CHECK_EN
                  if (w_bad) r_err <= 1'b1;
`endif
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);
   assign arvalid_m_inf = (r_state == AR);
   assign araddr_m_inf  = r_araddr;
   assign rready_m_inf  = (r_state == RD) && sram_ready;
   assign sram_we       = w_beat;
   assign sram_addr     = r_cnt;
   assign sram_wdata    = w_beat ? rdata_m_inf : '0;
   assign arid_m_inf    = '0;
   assign arlen_m_inf   = 8'(BEATS - 1);
   assign arsize_m_inf  = AXI_SIZE_16B;
   assign arburst_m_inf = AXI_INCR;

endmodule

// File: tb/tb_mra_frame_fetch.sv
// Self-checking bench for mra_frame_fetch: table of fetch scenarios plus reset-abort sequence.
module tb_mra_frame_fetch;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [4:0]   frame_id;
   logic         map_sel;
   logic         busy, done, err;
   logic         sram_ready;
   logic         sram_we;
   logic [6:0]   sram_addr;
   logic [127:0] sram_wdata;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid, arready;
   logic [3:0]   rid;
   logic [127:0] rdata;
   logic [1:0]   rresp;
   logic         rlast, rvalid, rready;

   int n_chk  = 0;
   int n_fail = 0;
   logic err_exp;

   always #5 clk = ~clk;

   mra_frame_fetch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .frame_id      (frame_id),
      .map_sel       (map_sel),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .sram_ready    (sram_ready),
      .sram_we       (sram_we),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .arid_m_inf    (arid),
      .araddr_m_inf  (araddr),
      .arlen_m_inf   (arlen),
      .arsize_m_inf  (arsize),
      .arburst_m_inf (arburst),
      .arvalid_m_inf (arvalid),
      .arready_m_inf (arready),
      .rid_m_inf     (rid),
      .rdata_m_inf   (rdata),
      .rresp_m_inf   (rresp),
      .rlast_m_inf   (rlast),
      .rvalid_m_inf  (rvalid),
      .rready_m_inf  (rready)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_done"},    done, 0);
      chk({tag, "_err"},     err, 0);
      chk({tag, "_we"},      sram_we, 0);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_rready"},  rready, 0);
      chk({tag, "_addr"},    sram_addr, 0);
      chk({tag, "_araddr"},  araddr, 0);
      chk({tag, "_wdata"},   sram_wdata, 0);
   endtask

   // One complete fetch; abort_at >= 0 pulls reset when that beat index is presented.
   task automatic run_fetch(input logic [4:0] fid, input logic msel, input logic [31:0] exp_addr,
                            input int ar_dly, input int gap, input int stall, input int bad_beat,
                            input int last_beat, input int abort_at, input bit idx_data,
                            input bit start_in_done);
      logic [127:0] data;
      int           n;
      int           cyc;
      bit           acc;
      bit           bad;
      start = 1'b1; frame_id = fid; map_sel = msel;
      #1;
      chk("idle_busy", busy, 0);
      next_cycle();
      err_exp = 1'b0;
      for (int i = 0; i <= ar_dly; i++) begin
         arready  = (i == ar_dly);
         start    = 1'($urandom);
         frame_id = 5'($urandom);
         map_sel  = 1'($urandom);
         #1;
         chk("ar_valid",  arvalid, 1);
         chk("ar_addr",   araddr, exp_addr);
         chk("ar_len",    arlen, 127);
         chk("ar_busy",   busy, 1);
         chk("ar_err",    err, err_exp);
         chk("ar_rready", rready, 0);
         next_cycle();
      end
      n = 0; cyc = 0;
      data = idx_data ? 128'(0) : rnd128();
      while (n < 128 && cyc < 5000) begin
         rvalid     = idx_data ? 1'b1 : ($urandom_range(99) >= gap);
         sram_ready = idx_data ? 1'b1 : ($urandom_range(99) >= stall);
         rdata      = data;
         rresp      = (n == bad_beat) ? 2'b10 : 2'b00;
         rlast      = (n == last_beat);
         arready    = 1'($urandom);
         start      = 1'($urandom);
         frame_id   = 5'($urandom);
         if (n == abort_at) begin
            rvalid = 1'b1;
            rst_n  = 1'b0;
            #1;
            chk_all_zero("abort");
            next_cycle();
            rst_n = 1'b1; rvalid = 1'b0; start = 1'b0; err_exp = 1'b0;
            next_cycle();
            return;
         end
         #1;
         acc = rvalid && sram_ready;
         chk("rd_rready", rready, sram_ready);
         chk("rd_we",     sram_we, acc);
         chk("rd_busy",   busy, 1);
         chk("rd_done",   done, 0);
         chk("rd_araddr", araddr, exp_addr);
         chk("rd_err",    err, err_exp);
         if (acc) begin
            chk("rd_addr",  sram_addr, 128'(n));
            chk("rd_wdata", sram_wdata, data);
`ifdef RESP_CHECK_EN
            bad = (rresp != 2'b00) || (rid != 4'd0) || (rlast != (n == 127));
            if (bad) err_exp = 1'b1;
`else
            bad = 1'b0;
`endif
            n++;
            data = idx_data ? 128'(n) : rnd128();
         end
         next_cycle();
         cyc++;
      end
      chk("rd_beats", 128'(n), 128);
      if (idx_data) chk("rd_cycles", 128'(cyc), 128);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
      start = start_in_done; frame_id = 5'($urandom);
      #1;
      chk("done_pulse", done, 1);
      chk("done_busy",  busy, 1);
      chk("done_we",    sram_we, 0);
      chk("done_err",   err, err_exp);
      next_cycle();
      start = 1'b0;
      #1;
      chk("post_done",  done, 0);
      chk("post_busy",  busy, 0);
      chk("post_arv",   arvalid, 0);
      chk("post_err",   err, err_exp);
   endtask

   typedef struct {
      logic [4:0]  fid;
      logic        msel;
      logic [31:0] addr;
      int          ar_dly;
      int          gap;
      int          stall;
      int          bad_beat;
      int          last_beat;
      bit          idx;
      bit          sdone;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{5'd5,  1'b0, 32'h0001_2800, 3, 0,  0,  -1, 127, 1'b1, 1'b0};
      vecs[1] = '{5'd31, 1'b1, 32'h0002_F800, 0, 20, 30, -1, 127, 1'b0, 1'b1};
      vecs[2] = '{5'd0,  1'b0, 32'h0001_0000, 1, 40, 30, -1, 127, 1'b0, 1'b0};
      vecs[3] = '{5'd0,  1'b1, 32'h0002_0000, 2, 10, 30, 10, 127, 1'b0, 1'b1};
      vecs[4] = '{5'd17, 1'b0, 32'h0001_8800, 0, 0,  30, -1, 126, 1'b0, 1'b0};
      vecs[5] = '{5'd1,  1'b1, 32'h0002_0800, 5, 30, 30, -1, 127, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; frame_id = '0; map_sel = 1'b0; sram_ready = 1'b0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      err_exp = 1'b0;
      #12;
      chk_all_zero("reset");
      chk("const_arid",    arid, 0);
      chk("const_arlen",   arlen, 127);
      chk("const_arsize",  arsize, 3'b100);
      chk("const_arburst", arburst, 2'b01);
      rst_n = 1'b1;
      next_cycle();

      for (int v = 0; v < 6; v++) begin
         run_fetch(vecs[v].fid, vecs[v].msel, vecs[v].addr, vecs[v].ar_dly, vecs[v].gap,
                   vecs[v].stall, vecs[v].bad_beat, vecs[v].last_beat, -1, vecs[v].idx,
                   vecs[v].sdone);
      end

      run_fetch(5'd12, 1'b0, 32'h0001_6000, 1, 10, 30, -1, 127, 60, 1'b0, 1'b0);
      chk("after_abort_busy", busy, 0);
      run_fetch(5'd9, 1'b1, 32'h0002_4800, 2, 15, 30, -1, 127, -1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
